button_event_detector: RTL and testbench

//   Consumes the clean level from the debouncer and turns it into single-cycle

---
 rtl/button_event_detector.sv | 91 +++++++++
 tb/tb_button_event_detector.sv | 139 +++++++++++++
 2 files changed

// File: rtl/button_event_detector.sv
// button_event_detector: turns a debounced button level into press, release,
// short, long and auto-repeat single-clock events, advancing only on enable ticks.
module button_event_detector #(
   parameter logic ACTIVE_LEVEL     = 1'b1,
   parameter int   LONG_PRESS_TICKS = 512,
   parameter int   REPEAT_TICKS     = 128
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic data_i,
   output logic pressed_o,
   output logic press_o,
   output logic release_o,
   output logic short_o,
   output logic long_o,
   output logic repeat_o
);
   localparam int MAXT = LONG_PRESS_TICKS > REPEAT_TICKS ? LONG_PRESS_TICKS : REPEAT_TICKS;
   localparam int CW = MAXT > 1 ? $clog2(MAXT) : 1;
   localparam logic [CW-1:0] LAST_LONG = CW'(LONG_PRESS_TICKS - 1);
   localparam logic [CW-1:0] LAST_REP = REPEAT_TICKS == 0 ? '0 : CW'(REPEAT_TICKS - 1);
   typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic p, press_n, release_n, short_n, long_n, repeat_n;
   assign p = data_i == ACTIVE_LEVEL;
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      press_n   = 1'b0;
      release_n = 1'b0;
      short_n   = 1'b0;
      long_n    = 1'b0;
      repeat_n  = 1'b0;
      if (enable) begin
         case (state)
            IDLE: if (p) begin
               state_n = PRESSED;
               cnt_n   = '0;
               press_n = 1'b1;
            end
            PRESSED: if (!p) begin
               state_n   = IDLE;
               cnt_n     = '0;
               release_n = 1'b1;
               short_n   = 1'b1;
            end else if (cnt == LAST_LONG) begin
               state_n = HELD;
               cnt_n   = '0;
               long_n  = 1'b1;
            end else
               cnt_n = cnt + CW'(1);
            HELD: if (!p) begin
               state_n   = IDLE;
               cnt_n     = '0;
               release_n = 1'b1;
            end else if (REPEAT_TICKS != 0) begin
               // with repeat disabled the counter simply parks in HELD
               repeat_n = cnt == LAST_REP;
               cnt_n    = repeat_n ? '0 : cnt + CW'(1);
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         endcase
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         pressed_o <= 1'b0;
         press_o   <= 1'b0;
         release_o <= 1'b0;
         short_o   <= 1'b0;
         long_o    <= 1'b0;
         repeat_o  <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         pressed_o <= state_n != IDLE;
         press_o   <= press_n;
         release_o <= release_n;
         short_o   <= short_n;
         long_o    <= long_n;
         repeat_o  <= repeat_n;
      end
   end
endmodule

// File: tb/tb_button_event_detector.sv
// tb_button_event_detector: table vectors, directed corner sequences and random
// stimulus against an elapsed-tick reference model for R=2 and R=0 instances.
module tb_button_event_detector;
   localparam int L = 4;
   logic clock = 1'b0, reset = 1'b1, enable = 1'b0, data_i = 1'b0;
   logic pa, pra, rla, sha, lga, rpa, pb, prb, rlb, shb, lgb, rpb;
   logic [5:0] oa, ob;
   int total = 0, bad = 0;
   int down [2];
   int h [2];
   int rv [2] = '{2, 0};
   logic [5:0] ex [2];
   always #5 clock = ~clock;
   assign oa = {pa, pra, rla, sha, lga, rpa};
   assign ob = {pb, prb, rlb, shb, lgb, rpb};
   button_event_detector #(.ACTIVE_LEVEL(1'b1), .LONG_PRESS_TICKS(L), .REPEAT_TICKS(2)) dut_a (
      .clock(clock), .reset(reset), .enable(enable), .data_i(data_i),
      .pressed_o(pa), .press_o(pra), .release_o(rla), .short_o(sha), .long_o(lga), .repeat_o(rpa));
   button_event_detector #(.ACTIVE_LEVEL(1'b1), .LONG_PRESS_TICKS(L), .REPEAT_TICKS(0)) dut_b (
      .clock(clock), .reset(reset), .enable(enable), .data_i(data_i),
      .pressed_o(pb), .press_o(prb), .release_o(rlb), .short_o(shb), .long_o(lgb), .repeat_o(rpb));
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   // h counts ticks held since the press tick; events follow from h directly
   task automatic model_step(int i, bit r, bit e, bit d);
      bit pr, rl, sh, lg, rp;
      {pr, rl, sh, lg, rp} = '0;
      if (r) begin
         down[i] = 0;
         h[i] = 0;
      end else if (e) begin
         if (down[i] == 0 && d) begin
            down[i] = 1;
            h[i] = 0;
            pr = 1;
         end else if (down[i] != 0 && !d) begin
            rl = 1;
            sh = h[i] < L;
            down[i] = 0;
         end else if (down[i] != 0) begin
            h[i]++;
            lg = h[i] == L;
            rp = rv[i] != 0 && h[i] > L && (h[i] - L) % rv[i] == 0;
         end
      end
      ex[i] = {down[i] != 0, pr, rl, sh, lg, rp};
   endtask
   task automatic cyc(bit r, bit e, bit d);
      reset = r;
      enable = e;
      data_i = d;
      @(posedge clock);
      model_step(0, r, e, d);
      model_step(1, r, e, d);
      #1;
      chk("model_a", 32'(oa), 32'(ex[0]));
      chk("model_b", 32'(ob), 32'(ex[1]));
   endtask
   task automatic do_reset();
      cyc(1, 0, 0);
      cyc(1, 1, 0);
      cyc(0, 0, 0);
   endtask
   typedef struct packed {logic r; logic e; logic d; logic [5:0] exp;} vec_t;
   vec_t vt [16];
   logic [31:0] prs, lgs, rps, rls, shs;
   bit d;
   initial begin
      vt[0]  = '{1, 0, 0, 6'b000000};
      vt[1]  = '{0, 1, 1, 6'b110000};
      vt[2]  = '{0, 1, 1, 6'b100000};
      vt[3]  = '{0, 1, 0, 6'b001100};
      vt[4]  = '{0, 1, 0, 6'b000000};
      vt[5]  = '{0, 1, 1, 6'b110000};
      vt[6]  = '{0, 1, 1, 6'b100000};
      vt[7]  = '{0, 1, 1, 6'b100000};
      vt[8]  = '{0, 1, 1, 6'b100000};
      vt[9]  = '{0, 1, 0, 6'b001100};
      vt[10] = '{0, 1, 0, 6'b000000};
      vt[11] = '{0, 1, 1, 6'b110000};
      vt[12] = '{0, 0, 1, 6'b100000};
      vt[13] = '{0, 0, 0, 6'b100000};
      vt[14] = '{0, 1, 0, 6'b001100};
      vt[15] = '{0, 0, 0, 6'b000000};
      do_reset();
      for (int i = 0; i < 16; i++) begin
         cyc(vt[i].r, vt[i].e, vt[i].d);
         chk($sformatf("vec%0d", i), 32'(oa), 32'(vt[i].exp));
      end
      do_reset();
      {prs, lgs, rps, rls, shs} = '0;
      for (int t = 0; t < 11; t++) begin
         cyc(0, 1, t < 9);
         prs[t] = pra; lgs[t] = lga; rps[t] = rpa; rls[t] = rla; shs[t] = sha;
      end
      chk("held_press", prs, 32'h1);
      chk("held_long", lgs, 32'h10);
      chk("held_repeat", rps, 32'h140);
      chk("held_release", rls, 32'h200);
      chk("held_short", shs, 32'h0);
      do_reset();
      {prs, lgs} = '0;
      for (int c = 0; c < 15; c++) begin
         cyc(0, c % 3 == 0, 1);
         prs[c] = pra; lgs[c] = lga;
      end
      chk("slow_press", prs, 32'h1);
      chk("slow_long", lgs, 32'h1000);
      chk("slow_pressed", 32'(pa), 32'h1);
      for (int t = 0; t < 6; t++) cyc(0, 1, 1);
      cyc(1, 1, 1);
      chk("rst_outputs", 32'(oa), 32'h0);
      cyc(0, 0, 1);
      chk("rst_idle", 32'(oa), 32'h0);
      cyc(0, 1, 1);
      chk("rst_repress", 32'(oa), 32'b110000);
      do_reset();
      {lgs, rps, rls} = '0;
      for (int t = 0; t < 22; t++) begin
         cyc(0, 1, t < 20);
         lgs[t] = lgb; rps[t] = rpb; rls[t] = rlb;
      end
      chk("norep_long", lgs, 32'h10);
      chk("norep_repeat", rps, 32'h0);
      chk("norep_release", rls, 32'h100000);
      d = 0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(9) == 0) d = !d;
         cyc($urandom_range(199) == 0, $urandom_range(3) != 0, d);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
